// File: rtl/ul4_arb_if.sv
// Handshake bundle between two command requesters, the ul4_arb arbiter and its
// response consumer.
interface ul4_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_A;
  logic [3:0] req0_B;
  logic [1:0] req0_S;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_A;
  logic [3:0] req1_B;
  logic [1:0] req1_S;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_Out;
  logic       busy;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_S,
    input  req1_valid, req1_A, req1_B, req1_S,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_Out, busy
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_S,
    output req1_valid, req1_A, req1_B, req1_S,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_Out, busy
  );
endinterface

// File: rtl/ul4_arb.sv
// Round-robin arbiter/sequencer for the shared 4-bit logic unit ul4.
// Define UL4_ARB_FAST_EN to drop EXEC and compute the result on the accepting edge.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | arbitrate and accept one command
//   EXEC    | ul4 evaluates latched operands (absent in fast build)
//   RESP    | result held on the response channel until taken

module ul4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] s_i,
  output logic [3:0] out_o
);
  always_comb begin
    case (s_i)
      2'b00:   out_o = a_i & b_i;
      2'b01:   out_o = a_i | b_i;
      2'b10:   out_o = a_i ^ b_i;
      default: out_o = ~a_i;
    endcase
  end
endmodule

module ul4_arb #(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  ul4_arb_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic       prio_q, prio_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_out_q, rsp_out_d;
  logic       rsp_id_q, rsp_id_d;

  logic       grant0, grant1, accept, grant_id;
  logic [3:0] sel_a, sel_b, ul_a, ul_b, ul_out;
  logic [1:0] sel_s, ul_s;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio_q);

  assign bus.req0_ready = (state_q == ST_IDLE) & grant0 & rst_n;
  assign bus.req1_ready = (state_q == ST_IDLE) & grant1 & rst_n;

  assign accept   = bus.req0_ready | bus.req1_ready;
  assign grant_id = bus.req1_ready;

  assign sel_a = grant_id ? bus.req1_A : bus.req0_A;
  assign sel_b = grant_id ? bus.req1_B : bus.req0_B;
  assign sel_s = grant_id ? bus.req1_S : bus.req0_S;

`ifdef UL4_ARB_FAST_EN
  assign ul_a = sel_a;
  assign ul_b = sel_b;
  assign ul_s = sel_s;
`else
  logic [3:0] a_q, b_q;
  logic [1:0] s_q;
  logic       id_q;

  // Operands are captured only on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 4'd0;
      b_q  <= 4'd0;
      s_q  <= 2'd0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      s_q  <= sel_s;
      id_q <= grant_id;
    end
  end

  assign ul_a = a_q;
  assign ul_b = b_q;
  assign ul_s = s_q;
`endif

  ul4 u_ul4 (
    .a_i   (ul_a),
    .b_i   (ul_b),
    .s_i   (ul_s),
    .out_o (ul_out)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          prio_d = ~grant_id;
`ifdef UL4_ARB_FAST_EN
          rsp_out_d   = ul_out;
          rsp_id_d    = grant_id;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
`ifdef UL4_ARB_FAST_EN
        state_d = ST_IDLE;
`else
        rsp_out_d   = ul_out;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= INIT_PRIO;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 4'd0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_Out   = rsp_out_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ul4_arb.sv
// Self-checking bench for ul4_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/result model.
module tb_ul4_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ul4_arb_if bus();
  ul4_arb #(.INIT_PRIO(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef UL4_ARB_FAST_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  int   total = 0;
  int   bad   = 0;
  logic prio_m;

  function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return 4'hF - a;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1,
                       input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] s0,
                       input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] s1);
    bus.req0_valid = v0; bus.req0_A = a0; bus.req0_B = b0; bus.req0_S = s0;
    bus.req1_valid = v1; bus.req1_A = a1; bus.req1_B = b1; bus.req1_S = s1;
    #1;
  endtask

  task automatic scramble;
    drive(1'b0, 1'b0, 4'($urandom), 4'($urandom), 2'($urandom),
          4'($urandom), 4'($urandom), 2'($urandom));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      step;
      lat++;
    end
  endtask

  // Present one command set, accept it, collect the response with rsp_ready held high.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] s0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] s1,
                         output logic r0, output logic r1, output int lat,
                         output logic [3:0] out, output logic id, output logic v_after);
    bus.rsp_ready = 1'b1;
    drive(v0, v1, a0, b0, s0, a1, b1, s1);
    r0 = bus.req0_ready;
    r1 = bus.req1_ready;
    step;
    scramble;
    wait_rsp(lat);
    out = bus.rsp_Out;
    id  = bus.rsp_id;
    step;
    v_after = bus.rsp_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 4'hA, 4'h7, 2'b00, 4'h5, 4'h3, 2'b01);
    step; step;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_Out !== 4'b0000) begin bad++; $display("FAIL reset_rsp_Out got=%b exp=0000", bus.rsp_Out); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%0b exp=0", bus.rsp_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%0b exp=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%0b exp=0", bus.req1_ready); end
    rst_n = 1'b1;
    prio_m = 1'b0;
    #1;
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL release_ready0 got=%0b exp=1", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL release_ready1 got=%0b exp=0", bus.req1_ready); end
    scramble;
    step;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_valid_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_contention;
    logic r0, r1, id, va;
    int lat;
    logic [3:0] out;
    for (int i = 0; i < 3; i++) begin
      logic g;
      logic [3:0] exp;
      g   = prio_m;
      exp = g ? 4'b1101 : 4'b1111;
      run_txn(1'b1, 1'b1, 4'b1010, 4'b0111, 2'b01, 4'b1010, 4'b0111, 2'b10, r0, r1, lat, out, id, va);
      total++; if (r0 !== (g == 1'b0)) begin bad++; $display("FAIL contention_ready0[%0d] got=%0b exp=%0b", i, r0, g == 1'b0); end
      total++; if (r1 !== (g == 1'b1)) begin bad++; $display("FAIL contention_ready1[%0d] got=%0b exp=%0b", i, r1, g == 1'b1); end
      total++; if (out !== exp) begin bad++; $display("FAIL contention_out[%0d] got=%b exp=%b", i, out, exp); end
      total++; if (id !== g) begin bad++; $display("FAIL contention_id[%0d] got=%0b exp=%0b", i, id, g); end
      prio_m = ~g;
    end
  endtask

  task automatic test_single;
    logic r0, r1, id, va;
    int lat;
    logic [3:0] out;
    run_txn(1'b1, 1'b0, 4'b1010, 4'b0111, 2'b00, 4'h0, 4'h0, 2'b00, r0, r1, lat, out, id, va);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%0b exp=1", r0); end
    total++; if (r1 !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%0b exp=0", r1); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (out !== 4'b0010) begin bad++; $display("FAIL single_out got=%b exp=0010", out); end
    total++; if (id !== 1'b0) begin bad++; $display("FAIL single_id got=%0b exp=0", id); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0b exp=0", va); end
    prio_m = 1'b1;
  endtask

  task automatic test_backpressure;
    int lat;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'b0110, 4'b0011, 2'b10);
    step;
    scramble;
    wait_rsp(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
    drive(1'b1, 1'b1, 4'hF, 4'hF, 2'b00, 4'hF, 4'hF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step;
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, bus.rsp_valid); end
      total++; if (bus.rsp_Out !== 4'b0101) begin bad++; $display("FAIL bp_out[%0d] got=%b exp=0101", i, bus.rsp_Out); end
      total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL bp_id[%0d] got=%0b exp=1", i, bus.rsp_id); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%0b exp=1", i, bus.busy); end
      total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_readies[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); end
    end
    scramble;
    bus.rsp_ready = 1'b1;
    step;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b exp=0", bus.rsp_valid); end
    prio_m = 1'b0;
  endtask

  task automatic test_reset_midop;
    logic r0, r1, id, va;
    int lat;
    logic [3:0] out;
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 4'b1100, 4'b1010, 2'b00, 4'h0, 4'h0, 2'b00);
    step;
    scramble;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midop_busy_pre got=%0b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%0b exp=0", bus.busy); end
    step; step;
    rst_n = 1'b1;
    prio_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_no_retry[%0d] got=%0b exp=0", i, bus.rsp_valid); end
    end
    run_txn(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'b1010, 4'($urandom), 2'b11, r0, r1, lat, out, id, va);
    total++; if (r1 !== 1'b1) begin bad++; $display("FAIL midop_ready1 got=%0b exp=1", r1); end
    total++; if (out !== 4'b0101) begin bad++; $display("FAIL midop_out got=%b exp=0101", out); end
    total++; if (id !== 1'b1) begin bad++; $display("FAIL midop_id got=%0b exp=1", id); end
    prio_m = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat, cnt, gap;
    logic g;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] s0, s1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); s1 = 2'($urandom);
      drive(1'b1, 1'b1, a0, b0, s0, a1, b1, s1);
      cnt = 0;
      while (!(bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) && cnt < 8) begin
        step;
        cnt++;
      end
      g = prio_m;
      total++; if ({bus.req1_ready, bus.req0_ready} !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, g ? 2'b10 : 2'b01); end
      if (i > 0) begin
        gap = 1 + lat + cnt;
        total++; if (gap !== LAT + 2) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, gap, LAT + 2); end
      end
      step;
      wait_rsp(lat);
      total++; if (bus.rsp_Out !== (g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0))) begin bad++; $display("FAIL b2b_out[%0d] got=%b exp=%b", i, bus.rsp_Out, g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0)); end
      total++; if (bus.rsp_id !== g) begin bad++; $display("FAIL b2b_id[%0d] got=%0b exp=%0b", i, bus.rsp_id, g); end
      prio_m = ~g;
    end
    scramble;
    step;
  endtask

  task automatic test_random;
    logic v0, v1, g;
    logic [3:0] a0, b0, a1, b1, exp;
    logic [1:0] s0, s1;
    int bp, lat;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); s1 = 2'($urandom);
      bp = $urandom_range(0, 3);
      g  = (v0 && v1) ? prio_m : v1;
      exp = g ? ref_op(a1, b1, s1) : ref_op(a0, b0, s0);
      bus.rsp_ready = (bp == 0);
      drive(v0, v1, a0, b0, s0, a1, b1, s1);
      total++; if ({bus.req1_ready, bus.req0_ready} !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, g ? 2'b10 : 2'b01); end
      step;
      scramble;
      wait_rsp(lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      total++; if (bus.rsp_Out !== exp) begin bad++; $display("FAIL rnd_out[%0d] got=%b exp=%b", i, bus.rsp_Out, exp); end
      total++; if (bus.rsp_id !== g) begin bad++; $display("FAIL rnd_id[%0d] got=%0b exp=%0b", i, bus.rsp_id, g); end
      for (int k = 0; k < bp; k++) begin
        step;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_Out !== exp) begin bad++; $display("FAIL rnd_hold[%0d] valid=%0b out=%b exp_out=%b", i, bus.rsp_valid, bus.rsp_Out, exp); end
      end
      bus.rsp_ready = 1'b1;
      step;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_release[%0d] got=%0b exp=0", i, bus.rsp_valid); end
      prio_m = ~g;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 2'b00);
    test_reset;
    test_contention;
    test_single;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ul4_arb.md
# ul4_arb

Two-requester round-robin arbiter and sequencer for the shared 4-bit logic unit `ul4` (AND/OR/XOR/NOT-A selected by `S`). It accepts operand/opcode commands from two independent requesters over valid/ready handshakes and issues one at a time to a single internal `ul4` instance. It registers each result and returns it on a response channel tagged with the requester ID. It is the only access path to the shared `ul4`.

## Interface
- `INIT_PRIO`, default 0: requester holding priority after reset (0 or 1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 command valid.
- `req0_ready` out 1: requester 0 command accepted this cycle.
- `req0_A`, `req0_B` in 4: requester 0 operands.
- `req0_S` in 2: requester 0 opcode (00 AND, 01 OR, 10 XOR, 11 NOT A).
- `req1_valid`, `req1_ready`, `req1_A`, `req1_B`, `req1_S`: same for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out 1: requester ID owning the result.
- `rsp_Out` out 4: `ul4` result.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant requester `prio`.
  - Granted `reqN_ready` is combinational, `(state==IDLE) & reqN_valid & grant & rst_n`. The non-granted ready is 0.
- IDLE, on `valid & ready`:
  - Latch A, B, S and the granted ID into operand registers.
  - `prio` <= not granted ID.
  - Go to EXEC.
- EXEC: `ul4` is driven from the operand registers. Capture its `Out` into `rsp_Out`, load `rsp_id`, set `rsp_valid`=1, go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_Out` and `rsp_id` stable until `rsp_ready`=1.
  - On the `rsp_ready` edge, clear `rsp_valid` and return to IDLE.
  - Both req readies stay 0.
- Result arithmetic is exactly `ul4`: AND A&B, OR A|B, XOR A^B, NOT ~A. B is ignored for S=11. No carry, no width extension.
- Requester inputs are sampled only on the accepting edge. Later changes do not affect an in-flight operation.
- Reset values: state IDLE, `prio`=`INIT_PRIO`, `rsp_valid`=0, `rsp_Out`=0000, `rsp_id`=0, `busy`=0, `req0_ready`=`req1_ready`=0 while `rst_n`=0. Operand registers reset to 0.
- Reset asserted in EXEC or RESP aborts the operation. No response is emitted, and the aborted command is not retried.
- A requester dropping valid before acceptance is legal and has no side effects.

## Timing
- Accept at edge k; `rsp_valid` goes high after edge k+1 (result visible in cycle k+1 to k+2).
- With `rsp_ready` held at 1, `rsp_valid` is high for exactly one cycle, and IDLE can accept again after edge k+2.
- Maximum throughput: one command per 3 cycles.
- There are no combinational paths from request data to response outputs. The only combinational outputs are `reqN_ready`, driven from `reqN_valid` and state.
- With both requesters continuously valid, grants alternate 0,1,0,1 (starting from `INIT_PRIO`). Neither requester waits more than one transaction.

## Configuration
- `UL4_ARB_FAST_EN` defined:
  - EXEC is removed.
  - On the accepting edge, the `ul4` result is computed from the live request inputs and loaded directly into `rsp_Out`/`rsp_id` with `rsp_valid`=1; the state goes to RESP.
  - Latency is 1 cycle and throughput is one command per 2 cycles.
  - Operand registers are not instantiated.
- Undefined: three-state behaviour as described above.

## Test plan
- Reset: hold `rst_n`=0 with both valids high → all outputs 0 and both readies 0. Release → `req0` granted first (`INIT_PRIO`=0).
- Single request: `req0` A=1010, B=0111, S=00 → `req0_ready` high one cycle, then `rsp_valid` at k+1 with `rsp_Out`=0010, `rsp_id`=0.
- Contention: both valid at once, `req0` S=01 and `req1` S=10, with A=1010, B=0111 → first response 1111 id 0, second 1101 id 1. Re-present both → `req0` granted again.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_Out`/`rsp_id` stable, `busy`=1, both readies 0. Raising `rsp_ready` → `rsp_valid` drops next edge.
- Reset mid-op: assert `rst_n`=0 in EXEC → no `rsp_valid`. After release, `req1` A=1010, S=11 → `rsp_Out`=0101, `rsp_id`=1.
- `UL4_ARB_FAST_EN` build: `req1` A=1010, B=0111, S=10 → `rsp_valid` one cycle after accept with `rsp_Out`=1101. Back-to-back commands accepted every 2 cycles.
